// File: rtl/mash_modulator.sv
// rtl/mash_modulator.sv - MASH 1-1-..-1 delta-sigma modulator with LSB dither and fractional-word handshake
module mash_modulator #(
    parameter int          WIDTH     = 16,
    parameter int          ORDER     = 3,
    parameter bit          DITHER_EN = 1'b1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] frac_in,
    input  logic             frac_load,
    output logic             frac_pend,
    input  logic             dither_en,
    output logic [3:0]       y_out,
    output logic             y_valid,
    output logic [ORDER-1:0] c_out,
    output logic [WIDTH-1:0] e_out
);

    logic [WIDTH-1:0] active_q;
    logic [WIDTH-1:0] pend_q;
    logic             pend_flag_q;
    logic [WIDTH-1:0] acc_q  [ORDER];
    // bit j of a stage's history = that stage's carry delayed j enabled cycles
    logic [ORDER-1:0] hist_q [ORDER];
    logic [15:0]      lfsr_q;
    logic [2:0]       warm_cnt_q;
    logic [3:0]       y_q;
    logic             y_valid_q;

    logic             warm;
    logic             cin;
    logic             lfsr_fb;
    logic [WIDTH-1:0] stage_in [ORDER];
    logic [WIDTH:0]   sum_d    [ORDER];
    logic [3:0]       y_d;

    assign warm    = (warm_cnt_q == 3'(ORDER + 1));
    assign cin     = lfsr_q[0] & dither_en & DITHER_EN;
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_comb begin
        stage_in[0] = active_q;
        for (int k = 1; k < ORDER; k++) begin
            stage_in[k] = acc_q[k-1];
        end
        for (int k = 0; k < ORDER; k++) begin
            sum_d[k] = {1'b0, acc_q[k]} + {1'b0, stage_in[k]} + {{WIDTH{1'b0}}, (k == 0) && cin};
        end
    end

    // Noise cancellation aligned to the k-1 cycle lag of each later stage; 4-bit wrap is two's complement
    generate
        if (ORDER == 1) begin : g_ncl1
            assign y_d = {3'b0, hist_q[0][0]};
        end else if (ORDER == 2) begin : g_ncl2
            assign y_d = {3'b0, hist_q[0][1]} + {3'b0, hist_q[1][0]} - {3'b0, hist_q[1][1]};
        end else begin : g_ncl3
            assign y_d = {3'b0, hist_q[0][2]}
                       + {3'b0, hist_q[1][1]} - {3'b0, hist_q[1][2]}
                       + {3'b0, hist_q[2][0]} - {2'b0, hist_q[2][1], 1'b0} + {3'b0, hist_q[2][2]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q    <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                acc_q[k]  <= '0;
                hist_q[k] <= '0;
            end
            lfsr_q      <= LFSR_SEED;
            warm_cnt_q  <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
        end else begin
            if (frac_load) begin
                pend_q <= frac_in;
            end
            // a load arriving with the apply keeps the flag set for the newly captured word
            if (en && pend_flag_q) begin
                active_q    <= pend_q;
                pend_flag_q <= frac_load;
            end else if (frac_load) begin
                pend_flag_q <= 1'b1;
            end
            y_valid_q <= en & warm;
            if (en) begin
                for (int k = 0; k < ORDER; k++) begin
                    acc_q[k]  <= sum_d[k][WIDTH-1:0];
                    hist_q[k] <= (hist_q[k] << 1) | ORDER'(sum_d[k][WIDTH]);
                end
                y_q <= y_d;
                if (!warm) begin
                    warm_cnt_q <= warm_cnt_q + 3'd1;
                end
                if (DITHER_EN) begin
                    lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
                end
            end
        end
    end

    always_comb begin
        c_out = '0;
        for (int k = 0; k < ORDER; k++) begin
            c_out[k] = hist_q[k][0];
        end
    end

    assign y_out     = y_q;
    assign y_valid   = y_valid_q;
    assign frac_pend = pend_flag_q;
    assign e_out     = acc_q[ORDER-1];

endmodule

// File: tb/tb_mash_modulator.sv
// tb/tb_mash_modulator.sv - scoreboard bench for mash_modulator (ORDER=3 with dither, plus an ORDER=1 instance)
module tb_mash_modulator;

    logic        clk = 1'b0;
    logic        rst_n, en, frac_load, dither_en;
    logic [15:0] frac_in;

    logic        pend3, yv3;
    logic [3:0]  y3;
    logic [2:0]  c3;
    logic [15:0] e3;
    logic        pend1, yv1;
    logic [3:0]  y1;
    logic [0:0]  c1;
    logic [15:0] e1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mash_modulator #(.WIDTH(16), .ORDER(3), .DITHER_EN(1'b1), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .frac_in(frac_in), .frac_load(frac_load),
        .frac_pend(pend3), .dither_en(dither_en), .y_out(y3), .y_valid(yv3),
        .c_out(c3), .e_out(e3));

    mash_modulator #(.WIDTH(16), .ORDER(1), .DITHER_EN(1'b0), .LFSR_SEED(16'hACE1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .frac_in(frac_in), .frac_load(frac_load),
        .frac_pend(pend1), .dither_en(dither_en), .y_out(y1), .y_valid(yv1),
        .c_out(c1), .e_out(e1));

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ORDER=3 reference: spec-level integer model, one step per rising edge
    typedef struct {int y; int e; int c;} exp_t;
    exp_t sb[$];
    int   m_acc[3];
    int   m_h[3][3];
    int   m_lfsr, m_act, m_pend, m_pf, m_y, m_cnt;
    int   m_yv = 0;

    always @(posedge clk) begin : model
        int ap, cin, s0, s1, s2, ny, fb;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_acc[k] = 0;
                for (int j = 0; j < 3; j++) m_h[k][j] = 0;
            end
            m_lfsr = 'hACE1; m_act = 0; m_pend = 0; m_pf = 0; m_y = 0; m_cnt = 0; m_yv = 0;
            sb.delete();
        end else begin
            ap = m_act;
            if (en && m_pf != 0) begin
                m_act = m_pend;
                m_pf  = int'(frac_load);
            end else if (frac_load) begin
                m_pf = 1;
            end
            if (frac_load) m_pend = int'(frac_in);
            m_yv = (en && m_cnt >= 4) ? 1 : 0;
            if (en) begin
                ny  = m_h[0][2] + m_h[1][1] - m_h[1][2] + m_h[2][0] - 2 * m_h[2][1] + m_h[2][2];
                cin = (m_lfsr & 1) & int'(dither_en);
                s0  = m_acc[0] + ap + cin;
                s1  = m_acc[1] + m_acc[0];
                s2  = m_acc[2] + m_acc[1];
                for (int k = 0; k < 3; k++) begin
                    m_h[k][2] = m_h[k][1];
                    m_h[k][1] = m_h[k][0];
                end
                m_h[0][0] = s0 >> 16; m_acc[0] = s0 & 'hFFFF;
                m_h[1][0] = s1 >> 16; m_acc[1] = s1 & 'hFFFF;
                m_h[2][0] = s2 >> 16; m_acc[2] = s2 & 'hFFFF;
                fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
                m_lfsr = (m_lfsr >> 1) | (fb << 15);
                m_y    = ny;
                if (m_cnt < 4) m_cnt++;
            end
            if (m_yv != 0) sb.push_back('{m_y, m_acc[2], m_h[2][0] * 4 + m_h[1][0] * 2 + m_h[0][0]});
        end
    end

    always @(negedge clk) begin : monitor
        exp_t x;
        int   ys;
        chk("y_valid", int'(yv3), m_yv);
        if (yv3) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                x  = sb.pop_front();
                ys = $signed(y3);
                chk("y_out", ys, x.y);
                chk("e_out", int'(e3), x.e);
                chk("c_out", int'(c3), x.c);
                chk("y_range", (ys >= -3 && ys <= 4) ? 1 : 0, 1);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; frac_load = 1'b0; dither_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t_e[4] = '{0, 0, 'h8000, 0};
        int t_y[4] = '{0, 0, 0, 0};
        int t_c[4] = '{0, 0, 0, 1};
        int t_v[4] = '{0, 0, 1, 1};
        int sum, nz, nz1, vcnt, guard, e_prev;
        logic [3:0]  sy;
        logic [15:0] se;
        logic [2:0]  sc;

        // reset with a load asserted: reset must win
        rst_n = 1'b0; en = 1'b0; frac_load = 1'b1; frac_in = 16'hFFFF; dither_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_y", int'(y3), 0);     chk("rst_yv", int'(yv3), 0);
        chk("rst_pend", int'(pend3), 0); chk("rst_c", int'(c3), 0);
        chk("rst_e", int'(e3), 0);
        chk("rst1_y", int'(y1), 0);    chk("rst1_pend", int'(pend1), 0);
        chk("rst1_e", int'(e1), 0);

        // ORDER=1, frac=0x8000: hand-derived first edges, then strict alternation
        rst_n = 1'b1; frac_load = 1'b1; frac_in = 16'h8000; en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            frac_load = 1'b0;
            if (k < 4) begin
                chk("o1_e", int'(e1), t_e[k]); chk("o1_y", int'(y1), t_y[k]);
                chk("o1_c", int'(c1), t_c[k]); chk("o1_v", int'(yv1), t_v[k]);
            end else begin
                chk("o1_e_alt", int'(e1), (k % 2 == 0) ? 'h8000 : 0);
                chk("o1_y_alt", int'(y1), (k % 2 == 0) ? 1 : 0);
                chk("o1_c_alt", int'(c1), (k % 2 == 1) ? 1 : 0);
            end
        end

        // frac=0 from reset: output stays zero
        do_reset();
        en = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (yv3) chk("zero_frac_y", int'(y3), 0);
        end

        // frac=0x4000: 1024 valid samples sum to 256 +/- 4
        frac_in = 16'h4000; frac_load = 1'b1;
        @(negedge clk);
        frac_load = 1'b0;
        sum = 0; vcnt = 0; guard = 0;
        while (vcnt < 1024 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (yv3) begin
                sum += $signed(y3);
                vcnt++;
            end
        end
        chk("valid_budget_4000", vcnt, 1024);
        chk("sum_frac4000", (sum >= 252 && sum <= 260) ? 256 : sum, 256);

        // en gating: outputs frozen, continuation checked by the scoreboard
        frac_in = 16'h1234; frac_load = 1'b1;
        @(negedge clk);
        frac_load = 1'b0;
        repeat (13) @(negedge clk);
        sy = y3; se = e3; sc = c3;
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_y", int'(y3), int'(sy)); chk("hold_e", int'(e3), int'(se));
            chk("hold_c", int'(c3), int'(sc)); chk("hold_yv", int'(yv3), 0);
        end
        en = 1'b1;
        repeat (40) @(negedge clk);

        // handshake
        do_reset();
        frac_in = 16'h1000; frac_load = 1'b1;
        @(negedge clk);
        frac_load = 1'b0;
        chk("hs_pend_set", int'(pend3), 1); chk("hs1_pend_set", int'(pend1), 1);
        repeat (2) begin
            @(negedge clk);
            chk("hs_pend_hold", int'(pend3), 1);
        end
        en = 1'b1;
        @(negedge clk);
        chk("hs_pend_clr", int'(pend3), 0);
        en = 1'b0; frac_in = 16'h2000; frac_load = 1'b1;
        @(negedge clk);
        frac_in = 16'h3000;
        @(negedge clk);
        frac_load = 1'b0;
        chk("hs_pend_b2b", int'(pend3), 1);
        en = 1'b1;
        @(negedge clk);
        chk("hs_pend_clr2", int'(pend3), 0);
        e_prev = int'(e1);
        @(negedge clk);
        chk("hs_applied_3000", (int'(e1) - e_prev) & 'hFFFF, 'h3000);
        en = 1'b0; frac_in = 16'h0500; frac_load = 1'b1;
        @(negedge clk);
        en = 1'b1; frac_in = 16'h0700;
        e_prev = int'(e1);
        @(negedge clk);
        frac_load = 1'b0;
        chk("hs_coincide_pend", int'(pend3), 1);
        chk("hs_coincide_old", (int'(e1) - e_prev) & 'hFFFF, 'h3000);
        e_prev = int'(e1);
        @(negedge clk);
        chk("hs_apply_0500", (int'(e1) - e_prev) & 'hFFFF, 'h0500);
        chk("hs_pend_clr3", int'(pend3), 0);
        e_prev = int'(e1);
        @(negedge clk);
        chk("hs_apply_0700", (int'(e1) - e_prev) & 'hFFFF, 'h0700);

        // dither with frac=0: activity, near-zero mean; the undithered build stays silent
        do_reset();
        dither_en = 1'b1; en = 1'b1;
        sum = 0; nz = 0; nz1 = 0;
        repeat (4096) begin
            @(negedge clk);
            if (yv3) begin
                sum += $signed(y3);
                if (y3 != 4'd0) nz++;
            end
            if (y1 != 4'd0) nz1++;
        end
        chk("dither_activity", (nz > 0) ? 1 : 0, 1);
        chk("dither_mean", (sum >= -4 && sum <= 4) ? 0 : sum, 0);
        chk("no_dither_build", nz1, 0);

        en = 1'b0;
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
